// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request sequencer.
package dma_pkg;

    localparam int NCH    = 4;
    localparam int AW_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_S1,
        ST_S2,
        ST_S3
    } dma_state_e;

    function automatic logic [1:0] oh2idx(input logic [NCH-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Rotating-priority channel selector; the served channel drops to lowest
// priority when update is pulsed.
module dma_rr_arbiter
    import dma_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic           update,
    input  logic [NCH-1:0] served,
    output logic [NCH-1:0] grant
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update) ptr_d = oh2idx(served) + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dma_request_sequencer.sv
// Four-channel single-transfer DMA request sequencer with hold/ack
// bus handshake and registered timing-stage outputs.
module dma_request_sequencer
    import dma_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] dreq,
    input  logic           hlda,
    input  logic           ready,
    input  logic           prog_we,
    input  logic [1:0]     prog_ch,
    input  logic [AW-1:0]  prog_addr,
    input  logic [AW-1:0]  prog_count,
    input  logic           prog_dir,
    output logic           hrq,
    output logic [NCH-1:0] dack,
    output logic [AW-1:0]  addr,
    output logic           wrflag,
    output logic           cs_n,
    output logic           tc,
    output logic           busy
);

    dma_state_e     state_q, state_d;
    logic [1:0]     act_q, act_d;
    logic [AW-1:0]  ch_addr_q [NCH];
    logic [AW-1:0]  ch_addr_d [NCH];
    logic [AW-1:0]  ch_cnt_q  [NCH];
    logic [AW-1:0]  ch_cnt_d  [NCH];
    logic [NCH-1:0] ch_dir_q, ch_dir_d;
    logic [NCH-1:0] en_q, en_d;

    logic           hrq_q, hrq_d;
    logic [NCH-1:0] dack_q, dack_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           wrflag_q, wrflag_d;
    logic           cs_n_q, cs_n_d;
    logic           tc_q, tc_d;
    logic           busy_q, busy_d;

    logic [NCH-1:0] req_v;
    logic [NCH-1:0] grant;
    logic           xfer;

    assign req_v = dreq & en_q;

    dma_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_v),
        .update (state_q == ST_S3),
        .served (NCH'(1) << act_q),
        .grant  (grant)
    );

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        ch_addr_d = ch_addr_q;
        ch_cnt_d = ch_cnt_q;
        ch_dir_d = ch_dir_q;
        en_d     = en_q;

        unique case (state_q)
            ST_IDLE: if (|req_v) state_d = ST_REQ;
            ST_REQ: begin
                if (!(|req_v)) begin
                    state_d = ST_IDLE;
                end else if (hlda) begin
                    state_d = ST_S1;
                    act_d   = oh2idx(grant);
                end
            end
            ST_S1: state_d = hlda ? ST_S2 : ST_IDLE;
            ST_S2: begin
                if (!hlda)      state_d = ST_IDLE;
                else if (ready) state_d = ST_S3;
            end
            ST_S3: begin
                state_d          = ST_IDLE;
                ch_addr_d[act_q] = ch_addr_q[act_q] + AW'(1);
                ch_cnt_d[act_q]  = ch_cnt_q[act_q] - AW'(1);
                if (ch_cnt_q[act_q] == '0) en_d[act_q] = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // The channel in flight is locked against reprogramming.
        if (prog_we && !(state_q != ST_IDLE && prog_ch == act_q)) begin
            ch_addr_d[prog_ch] = prog_addr;
            ch_cnt_d[prog_ch]  = prog_count;
            ch_dir_d[prog_ch]  = prog_dir;
            en_d[prog_ch]      = 1'b1;
        end

        xfer     = (state_d == ST_S1) || (state_d == ST_S2);
        hrq_d    = (state_d != ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        dack_d   = xfer ? (NCH'(1) << act_d) : '0;
        cs_n_d   = !xfer;
        addr_d   = addr_q;
        wrflag_d = wrflag_q;
        if (state_d == ST_S1) begin
            addr_d   = ch_addr_q[act_d];
            wrflag_d = ch_dir_q[act_d];
        end
        tc_d = (state_q == ST_S2) && (state_d == ST_S3) &&
               (ch_cnt_q[act_q] == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            act_q     <= '0;
            ch_addr_q <= '{default: '0};
            ch_cnt_q  <= '{default: '0};
            ch_dir_q  <= '0;
            en_q      <= '0;
            hrq_q     <= 1'b0;
            dack_q    <= '0;
            addr_q    <= '0;
            wrflag_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            ch_addr_q <= ch_addr_d;
            ch_cnt_q  <= ch_cnt_d;
            ch_dir_q  <= ch_dir_d;
            en_q      <= en_d;
            hrq_q     <= hrq_d;
            dack_q    <= dack_d;
            addr_q    <= addr_d;
            wrflag_q  <= wrflag_d;
            cs_n_q    <= cs_n_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
        end
    end

    assign hrq    = hrq_q;
    assign dack   = dack_q;
    assign addr   = addr_q;
    assign wrflag = wrflag_q;
    assign cs_n   = cs_n_q;
    assign tc     = tc_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_dma_request_sequencer.sv
// Scoreboard bench: tasks queue expected transfers, a bus monitor
// captures each completed or cut-short transfer and checks it.
module tb_dma_request_sequencer;

    typedef struct packed {
        logic [3:0]  dack;
        logic [15:0] addr;
        logic        wr;
        logic        tc;
        logic [7:0]  low;
        logic        ab;
        logic        unst;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  dreq = '0;
    logic        hlda;
    logic        ready = 1'b1;
    logic        prog_we = 1'b0;
    logic [1:0]  prog_ch = '0;
    logic [15:0] prog_addr = '0;
    logic [15:0] prog_count = '0;
    logic        prog_dir = 1'b0;
    logic        hrq;
    logic [3:0]  dack;
    logic [15:0] addr;
    logic        wrflag;
    logic        cs_n;
    logic        tc;
    logic        busy;

    logic        hlda_r = 1'b0;
    logic        drop = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    xfer_t exp_q[$];
    xfer_t cur;
    xfer_t want;
    logic  in_xfer = 1'b0;

    always #5 clk = ~clk;

    // CPU grants the bus one cycle after it is requested
    always @(posedge clk) hlda_r <= hrq;
    assign hlda = hlda_r & ~drop;

    dma_request_sequencer #(.AW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .dreq       (dreq),
        .hlda       (hlda),
        .ready      (ready),
        .prog_we    (prog_we),
        .prog_ch    (prog_ch),
        .prog_addr  (prog_addr),
        .prog_count (prog_count),
        .prog_dir   (prog_dir),
        .hrq        (hrq),
        .dack       (dack),
        .addr       (addr),
        .wrflag     (wrflag),
        .cs_n       (cs_n),
        .tc         (tc),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            if (!in_xfer) begin
                in_xfer  = 1'b1;
                cur      = '0;
                cur.dack = dack;
                cur.addr = addr;
                cur.wr   = wrflag;
            end else if (dack !== cur.dack || addr !== cur.addr ||
                         wrflag !== cur.wr) begin
                cur.unst = 1'b1;
            end
            cur.low = cur.low + 8'd1;
        end else if (in_xfer) begin
            in_xfer = 1'b0;
            cur.tc  = tc;
            cur.ab  = ~hrq;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL xfer_unexpected got=%h", cur);
            end else begin
                want = exp_q.pop_front();
                if (cur !== want) begin
                    miscompares++;
                    $display("FAIL xfer got dack=%b addr=%h wr=%b tc=%b low=%0d ab=%b unst=%b want dack=%b addr=%h wr=%b tc=%b low=%0d ab=%b unst=%b",
                        cur.dack, cur.addr, cur.wr, cur.tc, cur.low, cur.ab, cur.unst,
                        want.dack, want.addr, want.wr, want.tc, want.low, want.ab, want.unst);
                end
            end
        end
    end

    function automatic xfer_t mk(input logic [3:0] d, input logic [15:0] a,
                                 input logic w, input logic t,
                                 input logic [7:0] l, input logic ab);
        xfer_t x;
        x = '{dack: d, addr: a, wr: w, tc: t, low: l, ab: ab, unst: 1'b0};
        return x;
    endfunction

    task automatic program_ch(input logic [1:0] ch, input logic [15:0] a,
                              input logic [15:0] c, input logic d);
        @(negedge clk);
        prog_ch    = ch;
        prog_addr  = a;
        prog_count = c;
        prog_dir   = d;
        prog_we    = 1'b1;
        @(negedge clk);
        prog_we    = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int idle_n;
        int n;
        idle_n = 0;
        n = 0;
        repeat (2) @(negedge clk);
        while (idle_n < 6 && n < 500) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) idle_n++;
            else idle_n = 0;
        end
        if (idle_n < 6) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout busy=%b want idle", name, busy);
        end
    endtask

    task automatic wait_cs_low(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (cs_n !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cs_n !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_no_select cs_n=%b want 0", name, cs_n);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_pending got=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors += 7;
        if (hrq !== 1'b0) begin miscompares++; $display("FAIL rst_hrq got=%b want 0", hrq); end
        if (dack !== 4'b0) begin miscompares++; $display("FAIL rst_dack got=%b want 0000", dack); end
        if (addr !== 16'h0) begin miscompares++; $display("FAIL rst_addr got=%h want 0000", addr); end
        if (wrflag !== 1'b0) begin miscompares++; $display("FAIL rst_wrflag got=%b want 0", wrflag); end
        if (cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_cs_n got=%b want 1", cs_n); end
        if (tc !== 1'b0) begin miscompares++; $display("FAIL rst_tc got=%b want 0", tc); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b want 0", busy); end
        reset = 1'b1;
        dreq  = 4'b1111;
        repeat (6) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || hrq !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_enable busy=%b hrq=%b want 0 0", busy, hrq);
        end
        dreq = 4'b0;
    endtask

    task automatic test_burst;
        program_ch(2'd1, 16'h1000, 16'd2, 1'b1);
        exp_q.push_back(mk(4'b0010, 16'h1000, 1'b1, 1'b0, 8'd2, 1'b0));
        exp_q.push_back(mk(4'b0010, 16'h1001, 1'b1, 1'b0, 8'd2, 1'b0));
        exp_q.push_back(mk(4'b0010, 16'h1002, 1'b1, 1'b1, 8'd2, 1'b0));
        dreq = 4'b0010;
        wait_quiet("burst");
        vectors++;
        if (hrq !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_enable_cleared hrq=%b want 0", hrq);
        end
        dreq = 4'b0;
        check_drained("burst");
    endtask

    task automatic test_wait_states;
        program_ch(2'd0, 16'h0040, 16'd0, 1'b0);
        exp_q.push_back(mk(4'b0001, 16'h0040, 1'b0, 1'b1, 8'd5, 1'b0));
        ready = 1'b0;
        dreq  = 4'b0001;
        wait_cs_low("wait");
        repeat (4) @(negedge clk);
        ready = 1'b1;
        wait_quiet("wait");
        dreq = 4'b0;
        check_drained("wait");
    endtask

    task automatic test_wrap;
        program_ch(2'd2, 16'hFFFF, 16'd1, 1'b1);
        exp_q.push_back(mk(4'b0100, 16'hFFFF, 1'b1, 1'b0, 8'd2, 1'b0));
        exp_q.push_back(mk(4'b0100, 16'h0000, 1'b1, 1'b1, 8'd2, 1'b0));
        dreq = 4'b0100;
        wait_cs_low("wrap");
        dreq = 4'b0;
        wait_quiet("wrap_a");
        dreq = 4'b0100;
        wait_quiet("wrap_b");
        dreq = 4'b0;
        check_drained("wrap");
    endtask

    task automatic test_abort;
        program_ch(2'd3, 16'h2000, 16'd0, 1'b0);
        exp_q.push_back(mk(4'b1000, 16'h2000, 1'b0, 1'b0, 8'd2, 1'b1));
        exp_q.push_back(mk(4'b1000, 16'h2000, 1'b0, 1'b1, 8'd2, 1'b0));
        ready = 1'b0;
        dreq  = 4'b1000;
        wait_cs_low("abort");
        @(negedge clk);
        drop = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (hrq !== 1'b0) begin miscompares++; $display("FAIL abort_hrq got=%b want 0", hrq); end
        if (cs_n !== 1'b1) begin miscompares++; $display("FAIL abort_cs_n got=%b want 1", cs_n); end
        if (dack !== 4'b0) begin miscompares++; $display("FAIL abort_dack got=%b want 0000", dack); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b want 0", busy); end
        drop  = 1'b0;
        ready = 1'b1;
        wait_quiet("abort");
        dreq = 4'b0;
        check_drained("abort");
    endtask

    task automatic test_reset_mid;
        logic seen_busy;
        program_ch(2'd3, 16'h3000, 16'd5, 1'b1);
        exp_q.push_back(mk(4'b1000, 16'h3000, 1'b1, 1'b0, 8'd2, 1'b1));
        ready = 1'b0;
        dreq  = 4'b1000;
        wait_cs_low("rmid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors += 7;
        if (hrq !== 1'b0) begin miscompares++; $display("FAIL rmid_hrq got=%b want 0", hrq); end
        if (dack !== 4'b0) begin miscompares++; $display("FAIL rmid_dack got=%b want 0000", dack); end
        if (addr !== 16'h0) begin miscompares++; $display("FAIL rmid_addr got=%h want 0000", addr); end
        if (wrflag !== 1'b0) begin miscompares++; $display("FAIL rmid_wrflag got=%b want 0", wrflag); end
        if (cs_n !== 1'b1) begin miscompares++; $display("FAIL rmid_cs_n got=%b want 1", cs_n); end
        if (tc !== 1'b0) begin miscompares++; $display("FAIL rmid_tc got=%b want 0", tc); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got=%b want 0", busy); end
        reset = 1'b1;
        ready = 1'b1;
        dreq  = 4'b1111;
        seen_busy = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        vectors++;
        if (seen_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_dreq_ignored busy_seen=%b want 0", seen_busy);
        end
        dreq = 4'b0;
        check_drained("rmid");
    endtask

    task automatic test_rotation;
        program_ch(2'd0, 16'h0400, 16'd1, 1'b0);
        program_ch(2'd1, 16'h0500, 16'd0, 1'b1);
        program_ch(2'd2, 16'h0600, 16'd0, 1'b0);
        program_ch(2'd3, 16'h0700, 16'd0, 1'b1);
        exp_q.push_back(mk(4'b0001, 16'h0400, 1'b0, 1'b0, 8'd2, 1'b0));
        exp_q.push_back(mk(4'b0010, 16'h0500, 1'b1, 1'b1, 8'd2, 1'b0));
        exp_q.push_back(mk(4'b0100, 16'h0600, 1'b0, 1'b1, 8'd2, 1'b0));
        exp_q.push_back(mk(4'b1000, 16'h0700, 1'b1, 1'b1, 8'd2, 1'b0));
        exp_q.push_back(mk(4'b0001, 16'h0401, 1'b0, 1'b1, 8'd2, 1'b0));
        dreq = 4'b1111;
        wait_quiet("rot");
        dreq = 4'b0;
        check_drained("rot");
    endtask

    initial begin
        test_reset();
        test_burst();
        test_wait_states();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_rotation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
